// File: rtl/cpu_clk_ctrl_if.sv
`timescale 1ns/1ps
// Signal bundle between the CPU clock-enable controller and its environment.
// The master side drives the divided clock, run/step/halt controls; the
// slave side (the controller) returns the enable pulse and status.
interface cpu_clk_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 div_clk;
  logic                 run_sw;
  logic                 step_btn;
  logic                 halt_req;
  logic                 cpu_ce;
  logic [1:0]           state;
  logic                 halted;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    output div_clk, run_sw, step_btn, halt_req,
    input  cpu_ce, state, halted, cycle_count
  );

  modport slave (
    input  div_clk, run_sw, step_btn, halt_req,
    output cpu_ce, state, halted, cycle_count
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
`timescale 1ns/1ps
// CPU clock-enable controller.
// Synchronises the divided clock onto the fast clock and converts each of
// its rising edges into a single-cycle enable for the CPU core. A
// run/halt/single-step state machine decides which of those enables reach
// the core. All state lives on clk; nothing here gates a clock.
module cpu_clk_ctrl #(
  parameter int DEBOUNCE_WIDTH  = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 32
) (
  input logic           clk,
  input logic           rst_n,
  cpu_clk_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_WAIT = 2'b10,
    ST_STEP_DONE = 2'b11
  } state_t;

  localparam logic [DEBOUNCE_WIDTH-1:0] DB_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  // divided-clock synchroniser and edge detect
  logic div_s1;
  logic div_s2;
  logic div_s3;
  logic tick;

  // run switch synchroniser
  logic run_s1;
  logic run_s;

  // step button synchroniser and debounce
  logic                      btn_s1;
  logic                      btn_s2;
  logic                      btn_db;
  logic [DEBOUNCE_WIDTH-1:0] db_cnt;
  logic                      step_req;

  // control state
  logic                 halt_latched;
  state_t               state_q;
  logic                 cpu_ce;
  logic [CNT_WIDTH-1:0] count_q;

  // Two-flop synchroniser for div_clk plus a third flop for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_s1 <= 1'b0;
      div_s2 <= 1'b0;
      div_s3 <= 1'b0;
    end else begin
      div_s1 <= bus.div_clk;
      div_s2 <= div_s1;
      div_s3 <= div_s2;
    end
  end

  // Two-flop synchroniser for the run switch level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      run_s1 <= bus.run_sw;
      run_s  <= run_s1;
    end
  end

  // Two-flop synchroniser for the raw step button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= bus.step_btn;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: accept a new button level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive cycles; a press (0->1 of
  // the accepted level) raises step_req for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db   <= 1'b0;
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else if (btn_s2 == btn_db) begin
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else if (db_cnt == DB_LAST) begin
      btn_db   <= btn_s2;
      db_cnt   <= '0;
      step_req <= btn_s2;
    end else begin
      db_cnt   <= db_cnt + DEBOUNCE_WIDTH'(1);
      step_req <= 1'b0;
    end
  end

  // A halt from the core while running sticks until the run switch drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_latched <= 1'b0;
    end else if (!run_s) begin
      halt_latched <= 1'b0;
    end else if ((state_q == ST_RUN) && bus.halt_req) begin
      halt_latched <= 1'b1;
    end
  end

  // Edge detect and enable gating; the RUN-state suppression must act in the
  // same cycle as the halt/run-drop, so this stays combinational
  always_comb begin
    tick   = div_s2 & ~div_s3;
    cpu_ce = 1'b0;
    case (state_q)
      ST_RUN:       cpu_ce = tick & ~bus.halt_req & run_s;
      ST_STEP_WAIT: cpu_ce = tick;
      default:      cpu_ce = 1'b0;
    endcase
  end

  // Run/halt/single-step state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
    end else begin
      case (state_q)
        ST_HALT: begin
          // run wins over a simultaneous step request, which is then lost
          if (run_s && !halt_latched) begin
            state_q <= ST_RUN;
          end else if (step_req) begin
            state_q <= ST_STEP_WAIT;
          end
        end
        ST_RUN: begin
          if (!run_s || bus.halt_req) begin
            state_q <= ST_HALT;
          end
        end
        ST_STEP_WAIT: begin
          if (tick) begin
            state_q <= ST_STEP_DONE;
          end
        end
        ST_STEP_DONE: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  // Count issued enables; wraps silently at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (cpu_ce) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.cpu_ce      = cpu_ce;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.cycle_count = count_q;

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Downstream consumer of the clock divider's slow output. Runs on the fast board clock, synchronises the divided clock, and turns each rising edge into a one-cycle clock-enable pulse for the CPU core. A run/halt/single-step state machine gates that pulse, driven by a run switch, a debounced step button and a halt request from the core. All CPU registers run on clk and advance only when cpu_ce=1; no gated clocks.

Parameters:
DEBOUNCE_WIDTH, 16, width of the step-button debounce counter
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles needed to accept a new step_btn level (must fit DEBOUNCE_WIDTH)
CNT_WIDTH, 32, width of cycle_count

Ports:
clk  input  1  fast system clock; same clock that feeds the divider
rst_n  input  1  asynchronous active-low reset
div_clk  input  1  divided clock from the divider; treated as asynchronous data
run_sw  input  1  run switch level; 1 = free-run requested
step_btn  input  1  raw step push-button; bouncy, asynchronous
halt_req  input  1  level from CPU core (e.g. break/syscall halt), synchronous to clk
cpu_ce  output  1  one-clk-cycle enable; CPU advances one instruction per pulse
state  output  2  FSM state: 00 HALT, 01 RUN, 10 STEP_WAIT, 11 STEP_DONE
halted  output  1  1 when state==HALT
cycle_count  output  CNT_WIDTH  number of cpu_ce pulses issued since reset

Behaviour:
- Reset (rst_n=0, asynchronous): state=HALT, cpu_ce=0, halted=1, cycle_count=0, all synchronisers, debounce counter, debounced level, step_req and halt_latched = 0. Applies immediately, including mid-step or mid-tick.
- div_clk: 2-FF synchroniser, then a third flop for edge detect. tick = s2 & ~s3. One tick per div_clk rising edge; tick asserts on the 3rd clk rising edge after div_clk rises (setup met). Falling edges ignored.
- run_sw: 2-FF synchroniser only (run_s). No debounce.
- step_btn: 2-FF sync, then debounce. Counter resets to 0 whenever the synced input equals the debounced level; otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears. A 0->1 transition of the debounced level sets step_req for one cycle, consumed as described below.
- halt_latched: next value = run_s ? (halt_latched | (state==RUN & halt_req)) : 0. The core's halt sticks until the user drops run_sw.
- FSM (registered; cpu_ce is combinational from state and tick, registered no further):
  HALT: if run_s & ~halt_latched -> RUN (run beats step; a step_req in the same cycle is dropped); else if step_req -> STEP_WAIT; cpu_ce=0.
  RUN: cpu_ce = tick & ~halt_req & run_s. If ~run_s or halt_req -> HALT. The transition and cpu_ce suppression happen in the same cycle.
  STEP_WAIT: cpu_ce = tick. On tick -> STEP_DONE. Ignores run_sw and halt_req; a step always completes exactly one instruction.
  STEP_DONE: cpu_ce=0; unconditionally -> HALT next cycle.
- step_req pulses arriving outside HALT are discarded; they do not queue.
- cycle_count increments by 1 on every clk where cpu_ce=1; wraps 2^CNT_WIDTH-1 -> 0 silently.
- halted = (state==HALT), combinational.
- At most one cpu_ce per div_clk rising edge in every state.

Test Plan:
DEBOUNCE_CYCLES=4, div_clk period 20 clk. Release reset with run_sw=0 -> state=00, cpu_ce never 1 over 200 clk, cycle_count=0.
run_sw=1 -> state=01 within 3 clk; then exactly one cpu_ce pulse per div_clk edge, 3 clk after the edge; after 10 edges cycle_count=10.
In RUN, assert halt_req on the tick cycle -> cpu_ce=0 that cycle, state=00 next, count unchanged. Deassert halt_req -> stays HALT; run_sw 0->1 -> resumes RUN.
In HALT, step_btn bounces 1/0/1 for 2 clk, then holds 1 for 10 clk -> exactly one STEP_WAIT, one cpu_ce, STEP_DONE, HALT; count +1. Hold btn 100 clk more -> no further pulses.
Preload cycle_count to all-ones via forced run, then one tick -> cycle_count=0. Also: step_req and run_sw=1 in the same cycle -> RUN, no extra step.
Assert rst_n=0 mid-STEP_WAIT, between ticks -> state=00, cpu_ce=0, cycle_count=0 immediately, with no clk edge required.
